pc_source_reg: RTL and testbench

PC_SOURCE_REG -- requirements
Module: pc_source_reg

---
 rtl/pc_source_reg.sv | 124 ++++++++++++
 tb/tb_pc_source_reg.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_source_reg.sv
// PC register with N-way source select and a 3-state exception sequence.
// Ports: clk, reset (sync, active-low), selector, data_in (flattened
//   sources), pc_write, pc_write_cond, cond_true, stall, exc_req ->
//   pc_out, pc_next (comb), epc_out, exc_ack, sel_err, align_err.
// Optional: define PC_SOURCE_ALIGN_CHECK_EN to trap misaligned targets.
module pc_source_reg #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 5,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] EXC_VEC  = DATA_W'(32'h0000_00FC),
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        selector,
  input  logic [N_SRC*DATA_W-1:0] data_in,
  input  logic                    pc_write,
  input  logic                    pc_write_cond,
  input  logic                    cond_true,
  input  logic                    stall,
  input  logic                    exc_req,
  output logic [DATA_W-1:0]       pc_out,
  output logic [DATA_W-1:0]       pc_next,
  output logic [DATA_W-1:0]       epc_out,
  output logic                    exc_ack,
  output logic                    sel_err,
  output logic                    align_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAVE,
    S_JUMP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic             sel_ok;
  logic [SEL_W-1:0] sel_idx;
  logic             load_req;
  logic             misalign;
  logic             load_en;
  logic             epc_en;
  logic             jump_en;
  logic             sel_err_d;
  logic             align_err_d;

  // Out-of-range selectors fall back to source 0 so the
  // part-select never leaves the data_in vector.
  assign sel_ok  = (int'(selector) < N_SRC);
  assign sel_idx = sel_ok ? selector : '0;
  assign pc_next = data_in[sel_idx*DATA_W +: DATA_W];

  // pc_write dominates, so asserting both behaves as pc_write.
  assign load_req = !stall &&
                    (pc_write || (pc_write_cond && cond_true));

`ifdef PC_SOURCE_ALIGN_CHECK_EN
  assign misalign = |pc_next[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    load_en     = 1'b0;
    epc_en      = 1'b0;
    jump_en     = 1'b0;
    sel_err_d   = 1'b0;
    align_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (exc_req) begin
          state_d = S_SAVE;
        end else if (load_req) begin
          if (!sel_ok) begin
            sel_err_d = 1'b1;
          end else if (misalign) begin
            // Trap: pc_out stays put so EPC records it.
            align_err_d = 1'b1;
            state_d     = S_SAVE;
          end else begin
            load_en = 1'b1;
          end
        end
      end
      S_SAVE: begin
        epc_en  = 1'b1;
        state_d = S_JUMP;
      end
      S_JUMP: begin
        jump_en = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_out    <= RESET_PC;
      epc_out   <= '0;
      exc_ack   <= 1'b0;
      sel_err   <= 1'b0;
      align_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      exc_ack   <= jump_en;
      sel_err   <= sel_err_d;
      align_err <= align_err_d;
      if (load_en) begin
        pc_out <= pc_next;
      end else if (jump_en) begin
        pc_out <= EXC_VEC;
      end
      if (epc_en) begin
        epc_out <= pc_out;
      end
    end
  end

endmodule

// File: tb/tb_pc_source_reg.sv
// Bench for pc_source_reg: directed table, corner sequences
// and a randomized run against a behavioural model.
module tb_pc_source_reg;

  localparam int DW = 32;
  localparam int NS = 5;
  localparam logic [31:0] EXC = 32'h0000_00FC;

  logic          clk;
  logic          reset;
  logic [2:0]    selector;
  logic [NS*DW-1:0] data_in;
  logic          pc_write;
  logic          pc_write_cond;
  logic          cond_true;
  logic          stall;
  logic          exc_req;
  logic [DW-1:0] pc_out;
  logic [DW-1:0] pc_next;
  logic [DW-1:0] epc_out;
  logic          exc_ack;
  logic          sel_err;
  logic          align_err;

  logic [31:0] src [NS];

  int n_cmp = 0;
  int n_err = 0;

  pc_source_reg dut (
    .clk          (clk),
    .reset        (reset),
    .selector     (selector),
    .data_in      (data_in),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .cond_true    (cond_true),
    .stall        (stall),
    .exc_req      (exc_req),
    .pc_out       (pc_out),
    .pc_next      (pc_next),
    .epc_out      (epc_out),
    .exc_ack      (exc_ack),
    .sel_err      (sel_err),
    .align_err    (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    data_in = '0;
    for (int k = 0; k < NS; k++) begin
      data_in[k*DW +: DW] = src[k];
    end
  end

  typedef struct {
    logic        rst;
    logic [2:0]  sel;
    logic        pw;
    logic        pwc;
    logic        ct;
    logic        st;
    logic        ex;
    logic [31:0] e_pc;
    logic [31:0] e_epc;
    logic        e_ack;
    logic        e_se;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] s,
                       input logic pw, input logic pwc,
                       input logic ct, input logic st,
                       input logic ex);
    reset         = r;
    selector      = s;
    pc_write      = pw;
    pc_write_cond = pwc;
    cond_true     = ct;
    stall         = st;
    exc_req       = ex;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic r, input logic [2:0] s, input logic pw,
    input logic pwc, input logic ct, input logic st,
    input logic ex, input logic [31:0] pc,
    input logic [31:0] epc, input logic ack,
    input logic se);
    vec_t v;
    v.rst = r;  v.sel = s;  v.pw = pw;  v.pwc = pwc;
    v.ct = ct;  v.st = st;  v.ex = ex;
    v.e_pc = pc; v.e_epc = epc; v.e_ack = ack; v.e_se = se;
    return v;
  endfunction

  // Behavioural model state.
  logic [31:0] m_pc, m_epc;
  logic        m_ack, m_se, m_ae;
  int          m_left;  // cycles left in exception sequence
  logic        align_chk;

  task automatic model_step();
    logic [31:0] tgt;
    if (!reset) begin
      m_pc = 32'h0; m_epc = 32'h0;
      m_ack = 0; m_se = 0; m_ae = 0; m_left = 0;
      return;
    end
    m_ack = 0; m_se = 0; m_ae = 0;
    if (m_left == 2) begin
      m_epc = m_pc; m_left = 1;
    end else if (m_left == 1) begin
      m_pc = EXC; m_ack = 1; m_left = 0;
    end else if (exc_req) begin
      m_left = 2;
    end else if (!stall &&
                 (pc_write || (pc_write_cond && cond_true))) begin
      if (selector >= NS) begin
        m_se = 1;
      end else begin
        tgt = src[selector];
        if (align_chk && tgt[1:0] != 2'b00) begin
          m_ae = 1; m_left = 2;
        end else begin
          m_pc = tgt;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] exp_nx;
`ifdef PC_SOURCE_ALIGN_CHECK_EN
    align_chk = 1'b1;
`else
    align_chk = 1'b0;
`endif
    src[0] = 32'h500;  src[1] = 32'h40;
    src[2] = 32'h1234; src[3] = 32'h80;
    src[4] = 32'h200;
    drive(0, 0, 0, 0, 0, 0, 0);

    //        rst sel pw pwc ct st ex   pc     epc  ack se
    tbl[0]  = mk(0, 1, 1, 0, 0, 0, 0, 32'h0,    0,    0, 0);
    tbl[1]  = mk(1, 2, 1, 0, 0, 0, 0, 32'h1234, 0,    0, 0);
    tbl[2]  = mk(1, 7, 1, 0, 0, 0, 0, 32'h1234, 0,    0, 1);
    tbl[3]  = mk(1, 2, 0, 0, 0, 0, 0, 32'h1234, 0,    0, 0);
    tbl[4]  = mk(1, 3, 0, 1, 0, 0, 0, 32'h1234, 0,    0, 0);
    tbl[5]  = mk(1, 3, 0, 1, 1, 0, 0, 32'h80,   0,    0, 0);
    tbl[6]  = mk(1, 2, 1, 0, 0, 1, 0, 32'h80,   0,    0, 0);
    tbl[7]  = mk(1, 4, 1, 1, 0, 0, 0, 32'h200,  0,    0, 0);
    tbl[8]  = mk(1, 2, 1, 0, 0, 0, 1, 32'h200,  0,    0, 0);
    tbl[9]  = mk(1, 2, 1, 0, 0, 1, 0, 32'h200, 32'h200, 0, 0);
    tbl[10] = mk(1, 2, 1, 0, 0, 1, 0, EXC,    32'h200, 1, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, EXC,    32'h200, 0, 0);
    tbl[12] = mk(1, 1, 1, 0, 0, 0, 0, 32'h40, 32'h200, 0, 0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].sel, tbl[i].pw, tbl[i].pwc,
            tbl[i].ct, tbl[i].st, tbl[i].ex);
      tick();
      chk($sformatf("t%0d pc", i), pc_out, tbl[i].e_pc);
      chk($sformatf("t%0d epc", i), epc_out, tbl[i].e_epc);
      chk($sformatf("t%0d ack", i), 32'(exc_ack), 32'(tbl[i].e_ack));
      chk($sformatf("t%0d se", i), 32'(sel_err), 32'(tbl[i].e_se));
      chk($sformatf("t%0d ae", i), 32'(align_err), 32'h0);
    end

    // pc_next mux, including out-of-range fallback to source 0.
    for (int s = 0; s < 8; s++) begin
      drive(1, 3'(s), 0, 0, 0, 0, 0);
      #1;
      exp_nx = (s < NS) ? src[s] : src[0];
      chk($sformatf("nx%0d", s), pc_next, exp_nx);
    end

    // Reset during EXC_SAVE aborts the sequence.
    drive(1, 2, 1, 0, 0, 0, 0); tick();
    drive(1, 2, 0, 0, 0, 0, 1); tick();
    chk("rs pc0", pc_out, 32'h1234);
    drive(0, 2, 0, 0, 0, 0, 0); tick();
    chk("rs pc", pc_out, 32'h0);
    chk("rs epc", epc_out, 32'h0);
    chk("rs ack", 32'(exc_ack), 32'h0);
    drive(1, 2, 1, 0, 0, 0, 0); tick();
    chk("rs idle", pc_out, 32'h1234);
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    chk("rs ack2", 32'(exc_ack), 32'h0);
    chk("rs epc2", epc_out, 32'h0);

    // exc_req held high: back-to-back sequences.
    drive(1, 1, 1, 0, 0, 0, 1);
    tick(); chk("h1 pc", pc_out, 32'h1234);
    tick(); chk("h2 epc", epc_out, 32'h1234);
    tick(); chk("h3 pc", pc_out, EXC);
    chk("h3 ack", 32'(exc_ack), 32'h1);
    tick(); chk("h4 ack", 32'(exc_ack), 32'h0);
    chk("h4 pc", pc_out, EXC);
    tick(); chk("h5 epc", epc_out, EXC);
    tick(); chk("h6 ack", 32'(exc_ack), 32'h1);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick(); chk("h7 ack", 32'(exc_ack), 32'h0);

    // Misaligned target.
    src[0] = 32'h10; src[1] = 32'h102;
    drive(1, 0, 1, 0, 0, 0, 0); tick();
    chk("ma pc0", pc_out, 32'h10);
    drive(1, 1, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    if (align_chk) begin
      chk("ma ae", 32'(align_err), 32'h1);
      chk("ma pc", pc_out, 32'h10);
      tick(); chk("ma epc", epc_out, 32'h10);
      chk("ma ae2", 32'(align_err), 32'h0);
      tick(); chk("ma vec", pc_out, EXC);
      chk("ma ack", 32'(exc_ack), 32'h1);
    end else begin
      chk("ma pc", pc_out, 32'h102);
      chk("ma ae", 32'(align_err), 32'h0);
    end

    // Randomized run against the model.
    drive(0, 0, 0, 0, 0, 0, 0);
    model_step(); tick();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NS; k++) src[k] = $urandom;
      drive(($urandom_range(0, 39) != 0),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0));
      #1;
      exp_nx = (selector < NS) ? src[selector] : src[0];
      chk($sformatf("r%0d nx", i), pc_next, exp_nx);
      model_step();
      tick();
      chk($sformatf("r%0d pc", i), pc_out, m_pc);
      chk($sformatf("r%0d epc", i), epc_out, m_epc);
      chk($sformatf("r%0d ack", i), 32'(exc_ack), 32'(m_ack));
      chk($sformatf("r%0d se", i), 32'(sel_err), 32'(m_se));
      chk($sformatf("r%0d ae", i), 32'(align_err), 32'(m_ae));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
